// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader.
//   state_t        : loader FSM encoding, also exported on the debug port
//   HDR_BYTES      : bytes in the word-count header
//   BYTES_PER_WORD : payload bytes packed into one instruction word
//   COUNT_WIDTH    : width of the word-count header field
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN (adds the CHK state).
package instr_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LOAD = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_WIDTH    = 16;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input plus instruction-memory write port of the loader.
//   in_data / in_valid / in_ready : byte stream; a byte moves on a rising
//       clock edge where in_valid && in_ready are both high. The sender
//       holds in_data stable while in_valid is high and not yet accepted.
//   mem_we / mem_addr / mem_wdata : single-cycle write strobe with byte
//       address and instruction word; address/data hold when mem_we is 0.
// Modports: master = loader side, slave = host link plus memory side.
interface instr_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    modport master (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_loader_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : synchronous clear of byte counter and shift register
//   byte_valid   : a byte is accepted this cycle
//   byte_in      : the accepted byte
//   word_valid   : high in the cycle the 4th byte of a word is accepted
//   word_out     : completed word (valid with word_valid), first byte in [31:24]
module instr_loader_byte_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word_out
);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] shift_q, shift_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear) begin
            cnt_d   = 2'd0;
            shift_d = 32'd0;
        end else if (byte_valid) begin
            // Counter wraps naturally after the 4th byte.
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[23:0], byte_in};
        end
    end

    // The completed word includes the byte arriving this cycle, so the
    // parent can register it on the same edge that accepts that byte.
    assign word_valid = byte_valid && !clear && (cnt_q == LAST_BYTE);
    assign word_out   = {shift_q[23:0], byte_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            shift_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end
endmodule

// File: rtl/instr_loader.sv
// Boot-time instruction-memory writer. Receives a 2-byte big-endian word
// count, then that many big-endian 32-bit words, writes them to consecutive
// word addresses and releases the core from reset once the program is in.
// Ports:
//   CLK, RST    : clock, asynchronous active-low reset
//   start       : one-cycle pulse starting a load from IDLE, DONE or ERR
//   bus         : byte stream in, instruction-memory write port out
//   core_rst_n  : 0 holds the core in reset
//   busy        : load in progress (HDR, LOAD, CHK)
//   done / err  : load finished successfully / failed
//   dbg_state   : current FSM state
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN -- a trailing XOR
// checksum byte over the payload is verified before the core is released.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int INSTR_MEM_DEPTH = 1024,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start,
    instr_loader_if.master bus,
    output logic           core_rst_n,
    output logic           busy,
    output logic           done,
    output logic           err,
    output state_t         dbg_state
);
    localparam int IDX_W = $clog2(INSTR_MEM_DEPTH) + 1;
    localparam logic [COUNT_WIDTH:0] MAX_N = (COUNT_WIDTH + 1)'(INSTR_MEM_DEPTH);
    localparam logic HDR_LAST = 1'(HDR_BYTES - 1);

    state_t                  state_q, state_d;
    logic                    hdr_idx_q, hdr_idx_d;
    logic [COUNT_WIDTH-1:0]  count_q, count_d;
    logic [IDX_W-1:0]        word_idx_q, word_idx_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    logic                    in_ready;
    logic                    xfer;
    logic                    pk_clear;
    logic                    pk_valid;
    logic                    pk_word_valid;
    logic [31:0]             pk_word;
    logic [COUNT_WIDTH-1:0]  hdr_n;
    logic [COUNT_WIDTH-1:0]  words_after;

    assign in_ready    = (state_q == HDR) || (state_q == LOAD) || (state_q == CHK);
    assign xfer        = bus.in_valid && in_ready;
    assign hdr_n       = {count_q[COUNT_WIDTH-1:8], bus.in_data};
    assign words_after = COUNT_WIDTH'(word_idx_q) + COUNT_WIDTH'(1);

    instr_loader_byte_packer u_byte_packer (
        .clk        (CLK),
        .rst_n      (RST),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_in    (bus.in_data),
        .word_valid (pk_word_valid),
        .word_out   (pk_word)
    );

    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        count_d     = count_q;
        word_idx_d  = word_idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pk_clear    = 1'b0;
        pk_valid    = 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                // start is the only way out of these states.
                if (start) begin
                    state_d   = HDR;
                    hdr_idx_d = 1'b0;
                    pk_clear  = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d    = 8'd0;
`endif
                end
            end
            HDR: begin
                if (xfer) begin
                    if (hdr_idx_q != HDR_LAST) begin
                        count_d[COUNT_WIDTH-1:8] = bus.in_data;
                        hdr_idx_d = 1'b1;
                    end else begin
                        count_d    = hdr_n;
                        word_idx_d = '0;
                        if ((hdr_n == '0) || ({1'b0, hdr_n} > MAX_N)) begin
                            state_d = ERR;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    pk_valid = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d   = csum_q ^ bus.in_data;
`endif
                    if (pk_word_valid) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ADDR_WIDTH'({word_idx_q, 2'b00});
                        mem_wdata_d = DATA_WIDTH'(pk_word);
                        word_idx_d  = word_idx_q + IDX_W'(1);
                        // Leave LOAD on the edge that registers the final
                        // write; done/core release are masked until the
                        // write strobe has dropped.
                        if (words_after == count_q) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                            state_d = CHK;
`else
                            state_d = DONE;
`endif
                        end
                    end
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    state_d = (bus.in_data == csum_q) ? DONE : ERR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            hdr_idx_q   <= 1'b0;
            count_q     <= '0;
            word_idx_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q      <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            count_q     <= count_d;
            word_idx_q  <= word_idx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign busy       = in_ready;
    assign done       = (state_q == DONE) && !mem_we_q;
    assign core_rst_n = done;
    assign err        = (state_q == ERR);
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader. Expected writes are derived from the
// byte payload (word i = bytes 4i..4i+3 big-endian at address 4i) and
// checked by one monitor on every negative clock edge.
module tb_instr_loader;
    import instr_loader_pkg::*;

    localparam int DEPTH = 1024;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   start = 1'b0;
    logic   core_rst_n, busy, done, err;
    state_t dbg_state;

    instr_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    instr_loader #(
        .DATA_WIDTH      (32),
        .INSTR_MEM_DEPTH (DEPTH),
        .ADDR_WIDTH      (32)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .start      (start),
        .bus        (bus),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          last_we_cyc = -1;
    int          done_rise_cyc = -1;
    logic        done_prev = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [7:0] p[$], input int i);
        return {p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]};
    endfunction

    function automatic logic [7:0] model_xor(input logic [7:0] p[$]);
        logic [7:0] x = 8'd0;
        foreach (p[i]) x ^= p[i];
        return x;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (bus.mem_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", bus.mem_we, 1'b0);
                end else begin
                    check("wr_addr", bus.mem_addr, exp_addr_q.pop_front());
                    check("wr_data", bus.mem_wdata, exp_q.pop_front());
                end
                last_we_cyc = cyc;
                last_addr   = bus.mem_addr;
                last_data   = bus.mem_wdata;
            end
            // The core may only run while a completed load is reported.
            check("core_rst_vs_done", core_rst_n, done);
            check("done_err_exclusive", done & err, 1'b0);
        end
        if (done && !done_prev) done_rise_cyc = cyc;
        done_prev = done;
    end

    // ---------------- drivers ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        bit r;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk); #1;
            if (r) ok = 1'b1;
        end
        if (!ok) check("byte_accept_timeout", ok, 1'b1);
        bus.in_valid = 1'b0;
    endtask

    // Full load: start, header, payload (plus checksum byte when enabled),
    // then wait for the outcome and check it against the model.
    task automatic do_load(input logic [15:0] n, input logic [7:0] payload[$],
                           input int max_gap, input logic [7:0] csum_delta,
                           input bit inject_start);
        bit hdr_ok;
        bit exp_ok;
        bit ended = 1'b0;
        hdr_ok = (n != 16'd0) && (n <= 16'(DEPTH));
        exp_ok = hdr_ok && (csum_delta == 8'd0);
        done_rise_cyc = -1;
        if (hdr_ok) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_addr_q.push_back(32'(i * 4));
                exp_q.push_back(model_word(payload, i));
            end
        end
        pulse_start();
        send_byte(n[15:8], 0);
        send_byte(n[7:0], 0);
        if (hdr_ok) begin
            for (int i = 0; i < payload.size(); i++) begin
                if (inject_start && i == 5) pulse_start();
                send_byte(payload[i], (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            send_byte(model_xor(payload) ^ csum_delta, 0);
`endif
        end
        for (int i = 0; i < 40 && !ended; i++) begin
            @(negedge clk); #1;
            if (done || err) ended = 1'b1;
        end
        check("load_ended", ended, 1'b1);
        check("load_done", done, exp_ok);
        check("load_err", err, !exp_ok);
        check("load_core_rst_n", core_rst_n, exp_ok);
        check("load_busy", busy, 1'b0);
        check("load_writes_left", exp_q.size(), 0);
        if (exp_ok) check("done_after_last_we", done_rise_cyc, last_we_cyc + 1);
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] p[$];
        logic [7:0] big[$];

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // Reset held with in_valid toggling: everything quiet.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.in_data  = 8'h5A;
            @(negedge clk);
            check("rst_ctrl", {bus.in_ready, bus.mem_we, busy, done, err, core_rst_n}, 6'b0);
            check("rst_addr", bus.mem_addr, 32'h0);
            check("rst_wdata", bus.mem_wdata, 32'h0);
            check("rst_state", dbg_state, IDLE);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // IDLE with valid high: nothing consumed, stays IDLE.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", bus.in_ready, 1'b0);
            check("idle_state", dbg_state, IDLE);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        // Two-word load, continuous valid. Model pinned to hand values.
        p = '{8'h20, 8'h10, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        check("model_w0", model_word(p, 0), 32'h20100005);
        check("model_w1", model_word(p, 1), 32'h8C090004);
        do_load(16'd2, p, 0, 8'h00, 1'b0);
        check("t1_last_addr", last_addr, 32'h4);
        check("t1_last_data", last_data, 32'h8C090004);
        check("t1_hold_addr", bus.mem_addr, 32'h4);
        check("t1_hold_data", bus.mem_wdata, 32'h8C090004);

        // Header errors: zero count, count above depth (0x0401 = 1025).
        p = {};
        do_load(16'h0000, p, 0, 8'h00, 1'b0);
        do_load(16'h0401, p, 0, 8'h00, 1'b0);

        // Three words gapless, then the same words with random gaps and a
        // start pulse mid-load that must be ignored.
        p = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67,
              8'h89, 8'hAB, 8'hCD, 8'hEF};
        do_load(16'd3, p, 0, 8'h00, 1'b0);
        check("t3_last_addr", last_addr, 32'h8);
        check("t3_last_data", last_data, 32'h89ABCDEF);
        do_load(16'd3, p, 3, 8'h00, 1'b1);
        check("t3g_last_addr", last_addr, 32'h8);
        check("t3g_last_data", last_data, 32'h89ABCDEF);

        // Reset after 6 payload bytes: first word written, then abandon.
        p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_addr_q.push_back(32'h0);
        exp_q.push_back(32'h11223344);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int i = 0; i < 6; i++) send_byte(p[i], 0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", dbg_state, IDLE);
        check("mid_rst_ctrl", {bus.in_ready, bus.mem_we, busy, done, err, core_rst_n}, 6'b0);
        check("mid_rst_addr", bus.mem_addr, 32'h0);
        check("mid_rst_word0_seen", exp_q.size(), 0);
        exp_q.delete();
        exp_addr_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        p = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        do_load(16'd1, p, 0, 8'h00, 1'b0);
        check("reload_addr", last_addr, 32'h0);
        check("reload_data", last_data, 32'hCAFEF00D);

        // Full depth: 1024 words, last at byte address 0xFFC.
        big = {};
        for (int i = 0; i < DEPTH * 4; i++) big.push_back(8'($urandom_range(0, 255)));
        do_load(16'd1024, big, 0, 8'h00, 1'b0);
        check("depth_last_addr", last_addr, 32'hFFC);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Checksum good (0x0F) then bad (0x0E).
        p = '{8'h01, 8'h02, 8'h04, 8'h08};
        check("model_xor", model_xor(p), 8'h0F);
        do_load(16'd1, p, 0, 8'h00, 1'b0);
        do_load(16'd1, p, 0, 8'h01, 1'b0);
        check("csum_bad_core_rst", core_rst_n, 1'b0);
        check("csum_bad_word_kept", last_data, 32'h01020408);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: the whole run is far shorter than this.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Boot-time writer for the core's instruction memory; the core is the reader of that memory.
- Receives a byte stream over valid/ready: 2-byte word-count header, then big-endian instruction words.
- Drives the instruction-memory write port (WE / address / INSTRUCTIONS) and holds the core in reset until the program is fully written.
- Sits beside TOP at the SoC level, between a host byte link (UART RX, JTAG bridge) and the core's load inputs.

Parameters:
- DATA_WIDTH, 32, instruction word width; must be 32.
- INSTR_MEM_DEPTH, 1024, maximum number of words accepted.
- ADDR_WIDTH, 32, width of the byte address driven to instruction memory.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction-memory write enable (to core WE)
- mem_addr  out  ADDR_WIDTH  byte address, always a multiple of 4
- mem_wdata  out  DATA_WIDTH  instruction word (to core INSTRUCTIONS)
- core_rst_n  out  1  0 = core held in reset
- busy  out  1  in HDR, LOAD or CHK
- done  out  1  load completed successfully
- err  out  1  load failed

Behaviour:
- Reset (async, RST=0):
  - state=IDLE.
  - in_ready, mem_we, mem_addr, mem_wdata, busy, done and err are all 0.
  - core_rst_n=0.
  - Reset mid-load abandons the load immediately; partially written memory is not cleared.
- Handshake: a byte transfers on a rising CLK edge with in_valid && in_ready. in_ready=1 only in HDR, LOAD and CHK.
- States:
  - IDLE: start -> HDR.
  - HDR: accepts 2 bytes forming count N, first byte = N[15:8].
    - After the 2nd byte: N==0 or N>INSTR_MEM_DEPTH -> ERR; else -> LOAD with word_idx=0.
  - LOAD: packs 4 bytes big-endian; the first byte of each word lands in [31:24].
    - The cycle after the 4th byte's handshake: mem_we=1 for exactly one cycle, mem_addr=word_idx*4, mem_wdata=packed word; then word_idx increments.
    - in_ready stays 1 during the write cycle, so back-to-back bytes are sustained.
    - After word N-1 is written -> CHK when CHECKSUM_EN is defined, else -> DONE.
  - CHK: see Optional Feature.
  - DONE: done=1 and core_rst_n=1, both starting the cycle after the final mem_we.
  - ERR: err=1, core_rst_n=0.
  - start in DONE or ERR: clear done/err, drive core_rst_n=0, go -> HDR in the next cycle.
- start while busy is ignored.
- in_valid outside the busy states is ignored; no byte is consumed.
- mem_addr and mem_wdata keep their last values when mem_we=0.
- word_idx width is clog2(INSTR_MEM_DEPTH)+1; mem_addr = {word_idx, 2'b00}, zero-extended to ADDR_WIDTH.

Optional Feature:
- Macro INSTR_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR accumulates every payload byte (header bytes excluded); it is cleared on entry to HDR.
  - CHK accepts one byte: equal to the accumulator -> DONE; else -> ERR.
  - Words already written stay in memory; core_rst_n stays 0 on mismatch.
- Not defined: no CHK state; LOAD goes straight to DONE.

Decomposition:
- Package instr_loader_pkg:
  - state enum (IDLE, HDR, LOAD, CHK, DONE, ERR)
  - HDR_BYTES=2
  - BYTES_PER_WORD=4
  - COUNT_WIDTH=16
- One sub-module, byte_packer:
  - 2-bit byte counter and 32-bit shift register, with clear input.
  - Asserts word_valid for one cycle on the 4th accepted byte.

Test Plan:
- Reset held low, in_valid=1 toggling -> all outputs 0, core_rst_n=0, no byte consumed.
- start; header 00 02; bytes 20 10 00 05 8C 09 00 04 with continuous valid:
  - mem_we pulses twice: (addr 0x0, 0x20100005), then (addr 0x4, 0x8C090004).
  - done=1 and core_rst_n=1 the cycle after the 2nd write.
- Header 00 00 -> err=1, no mem_we, core_rst_n=0. Header 04 01 with depth 1024 -> err=1.
- in_valid gapped randomly across a 3-word load -> same words and addresses as the gapless run; no write while a word is incomplete.
- RST asserted after 6 payload bytes -> immediate IDLE. A following start reloads correctly from address 0.
- CHECKSUM_EN defined, header 00 01, payload 01 02 04 08:
  - Checksum byte 0F -> done=1.
  - Checksum byte 0E -> err=1, core_rst_n=0.
